mem_boot_loader: RTL
====================

MEM_BOOT_LOADER -- requirements
Module: mem_boot_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 26'h0001000, the first memory word address written.
REQ-002 SHALL have parameter LOAD_COUNT, default 64, the number of 32-bit words to load (range 0..2^26).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port LD_DATA  input  32  boot word from the external loader.
REQ-006 SHALL have port LD_VALID  input  1  LD_DATA valid.
REQ-007 SHALL have port LD_READY  output  1  block accepts a word this cycle.
REQ-008 SHALL have port ADDR  output  26  memory word address.
REQ-009 SHALL have port MEM_DATA_IN  output  32  data driven to memory on write.
REQ-010 SHALL have port MEM_DATA_OUT  input  32  data returned by memory on read.
REQ-011 SHALL have ports READ, WRITE  output  1 each  memory strobes, never both high.
REQ-012 SHALL have port CPU_RST  output  1  active-low reset to the processor core.
REQ-013 SHALL have ports DONE, ERR  output  1 each  load complete; verify mismatch.

Function
REQ-014 SHALL implement states IDLE, WAIT, WRITE, CHECK, DONE.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to WAIT, or to DONE if LOAD_COUNT==0.
REQ-016 WAIT SHALL drive LD_READY=1; a word is accepted when LD_VALID&&LD_READY at a rising edge; it is registered and the FSM enters WRITE.
REQ-017 WRITE SHALL last one cycle with WRITE=1, READ=0, ADDR=BASE_ADDR+index, MEM_DATA_IN=accepted word; LD_READY=0.
REQ-018 After WRITE, the index SHALL increment; the FSM SHALL return to WAIT if index<LOAD_COUNT, else enter CHECK (macro on) or DONE (macro off).
REQ-019 Address arithmetic SHALL be modulo 2^26; BASE_ADDR+index past 26'h3FFFFFF SHALL wrap to 0.
REQ-020 Peak throughput SHALL be one word per two cycles; LD_VALID low in WAIT SHALL stall indefinitely with no strobes.
REQ-021 LD_DATA/LD_VALID outside WAIT SHALL be ignored.
REQ-022 DONE SHALL be absorbing until reset: DONE=1, LD_READY=0, READ=WRITE=0.
REQ-023 CPU_RST SHALL be 0 in every state except DONE with ERR=0, where it is 1 (from the first DONE cycle).
REQ-024 ADDR and MEM_DATA_IN SHALL hold their last value whenever no strobe is active.

Reset
REQ-025 While RST=0 at a rising edge: state=IDLE, index=0, LD_READY=0, READ=0, WRITE=0, ADDR=0, MEM_DATA_IN=0, CPU_RST=0, DONE=0, ERR=0, checksum=0.
REQ-026 Reset asserted mid-load SHALL abort at the next edge; any partly loaded words stay in memory and loading restarts at BASE_ADDR.

Configuration
REQ-027 Macro BOOT_LOADER_VERIFY_EN SHALL compile in read-back verification; XOR of all accepted words is accumulated during load.
REQ-028 With it defined, CHECK SHALL issue LOAD_COUNT reads (READ=1 one cycle each, ADDR from BASE_ADDR upward), sample MEM_DATA_OUT at the end of each READ cycle, XOR into a second accumulator, then enter DONE with ERR=1 if the accumulators differ.
REQ-029 With it undefined, CHECK SHALL be unreachable, READ SHALL be constant 0, ERR constant 0, and no accumulators synthesized.

Verification
REQ-030 Defaults, words 1..64 streamed with LD_VALID always 1 -> memory 'h0001000..'h000103F = 1..64, DONE and CPU_RST rise 128 cycles after WAIT entry (macro off).
REQ-031 LD_VALID toggled randomly -> no WRITE pulse without a preceding handshake, same final memory image, LD_READY never high in WRITE.
REQ-032 BASE_ADDR=26'h3FFFFFE, LOAD_COUNT=4, words A..D -> written to 'h3FFFFFE, 'h3FFFFFF, 'h0000000, 'h0000001.
REQ-033 LOAD_COUNT=0 -> DONE=1, CPU_RST=1 in the second cycle after reset release, no strobes.
REQ-034 Macro on, bench corrupts memory word 'h0001005 before CHECK -> ERR=1, DONE=1, CPU_RST stays 0; uncorrupted run -> ERR=0, CPU_RST=1.
REQ-035 RST driven low after 10 words then released -> all outputs at reset values next edge, reload starts at 'h0001000.

Source files
------------

// File: rtl/mem_boot_loader.sv
// Boot loader: streams LOAD_COUNT words from an external loader into memory, then releases
// CPU_RST. Define BOOT_LOADER_VERIFY_EN to add XOR read-back verification of the image.
module mem_boot_loader #(
    parameter logic [25:0] BASE_ADDR  = 26'h0001000,
    parameter int unsigned LOAD_COUNT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] LD_DATA,
    input  logic        LD_VALID,
    output logic        LD_READY,
    output logic [25:0] ADDR,
    output logic [31:0] MEM_DATA_IN,
    input  logic [31:0] MEM_DATA_OUT,
    output logic        READ,
    output logic        WRITE,
    output logic        CPU_RST,
    output logic        DONE,
    output logic        ERR
);
    // 27 bits so a full 2^26-word load is representable
    localparam logic [26:0] LoadCnt = 27'(LOAD_COUNT);

    typedef enum logic [2:0] {StIdle, StWait, StWrite, StCheck, StDone} state_e;

    state_e      state_q;
    logic [26:0] index_q;
    logic [26:0] index_nxt;
    logic        ld_ready_q;
    logic        write_q;
    logic [25:0] addr_q;
    logic [31:0] mem_data_q;
    logic        cpu_rst_q;
    logic        done_q;

`ifdef BOOT_LOADER_VERIFY_EN
    logic        read_q;
    logic        err_q;
    logic [31:0] acc_wr_q;
    logic [31:0] acc_rd_q;
    logic        mismatch;

    assign mismatch = (acc_rd_q ^ MEM_DATA_OUT) != acc_wr_q;
`endif

    assign index_nxt = index_q + 27'd1;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            index_q    <= '0;
            ld_ready_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
            read_q     <= 1'b0;
            err_q      <= 1'b0;
            acc_wr_q   <= '0;
            acc_rd_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (LoadCnt == 27'd0) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b1;
                    end else begin
                        state_q    <= StWait;
                        ld_ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (LD_VALID) begin
                        state_q    <= StWrite;
                        ld_ready_q <= 1'b0;
                        write_q    <= 1'b1;
                        addr_q     <= BASE_ADDR + index_q[25:0];
                        mem_data_q <= LD_DATA;
`ifdef BOOT_LOADER_VERIFY_EN
                        acc_wr_q   <= acc_wr_q ^ LD_DATA;
`endif
                    end
                end
                StWrite: begin
                    write_q <= 1'b0;
                    index_q <= index_nxt;
                    if (index_nxt < LoadCnt) begin
                        state_q    <= StWait;
                        ld_ready_q <= 1'b1;
                    end else begin
`ifdef BOOT_LOADER_VERIFY_EN
                        state_q <= StCheck;
                        read_q  <= 1'b1;
                        addr_q  <= BASE_ADDR;
                        index_q <= '0;
`else
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b1;
`endif
                    end
                end
`ifdef BOOT_LOADER_VERIFY_EN
                StCheck: begin
                    // MEM_DATA_OUT is the word at ADDR during this READ cycle
                    acc_rd_q <= acc_rd_q ^ MEM_DATA_OUT;
                    if (index_nxt < LoadCnt) begin
                        index_q <= index_nxt;
                        addr_q  <= BASE_ADDR + index_nxt[25:0];
                    end else begin
                        state_q   <= StDone;
                        read_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= mismatch;
                        cpu_rst_q <= ~mismatch;
                    end
                end
`endif
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign LD_READY    = ld_ready_q;
    assign WRITE       = write_q;
    assign ADDR        = addr_q;
    assign MEM_DATA_IN = mem_data_q;
    assign CPU_RST     = cpu_rst_q;
    assign DONE        = done_q;

`ifdef BOOT_LOADER_VERIFY_EN
    assign READ = read_q;
    assign ERR  = err_q;
`else
    logic [31:0] unused_mem_data;

    assign unused_mem_data = MEM_DATA_OUT;
    assign READ            = 1'b0;
    assign ERR             = 1'b0;
`endif

endmodule
